csa_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one `csa_32bit` carry-skip adder between `NREQ` requesters. Each requester presents operands over a valid/ready handshake. The arbiter grants at most one request per cycle and drives the granted operands through the combinational adder. It captures sum, carry-out, signed overflow and requester id in a single output register, which is drained over a second valid/ready handshake. The block sits between the issuing units and the shared 32-bit adder datapath.

---
 rtl/csa_rr_arbiter.sv | 154 +++++++++++++++
 tb/tb_csa_rr_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/csa_rr_arbiter.sv
// Round-robin arbiter that shares one 32-bit carry-skip adder between NREQ
// requesters; the result is held in a single registered response slot.

module csa_32bit (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    // 4-bit ripple blocks; a fully propagating block forwards its carry-in.
    always_comb begin
        logic w_c;
        logic w_blk_cin;
        logic w_rc;
        logic w_blk_p;
        logic w_p;
        logic w_g;
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        o_sum     = '0;
        w_c       = i_cin;
        w_blk_cin = 1'b0;
        w_rc      = 1'b0;
        w_blk_p   = 1'b0;
        w_p       = 1'b0;
        w_g       = 1'b0;
        for (int blk = 0; blk < 8; blk++) begin
            w_blk_cin = w_c;
            w_rc      = w_c;
            w_blk_p   = 1'b1;
            for (int bt = 0; bt < 4; bt++) begin
                w_p                 = i_a[blk*4+bt] ^ i_b[blk*4+bt];
                w_g                 = i_a[blk*4+bt] & i_b[blk*4+bt];
                o_sum[blk*4+bt]     = w_p ^ w_rc;
                w_rc                = w_g | (w_p & w_rc);
                w_blk_p             = w_blk_p & w_p;
            end
            w_c = w_blk_p ? w_blk_cin : w_rc;
        end
        o_cout = w_c;
    end
endmodule

module csa_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ-1:0]    req_cin,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_sum,
    output logic               rsp_cout,
    output logic               rsp_ovf,
    output logic [IDW-1:0]     rsp_id
);
    logic [IDW-1:0]  r_ptr;
    logic            r_rsp_valid;
    logic [31:0]     r_rsp_sum;
    logic            r_rsp_cout;
    logic            r_rsp_ovf;
    logic [IDW-1:0]  r_rsp_id;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gnt_id;
    logic            w_found;
    logic            w_slot_free;
    logic            w_accept;
    logic [IDW-1:0]  w_ptr_next;
    logic [31:0]     w_a_arr [NREQ];
    logic [31:0]     w_b_arr [NREQ];
    logic [31:0]     w_a;
    logic [31:0]     w_b;
    logic            w_cin;
    logic [31:0]     w_sum;
    logic            w_cout;
    logic            w_ovf;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_a_arr[gi] = req_a[gi*32 +: 32];
        assign w_b_arr[gi] = req_b[gi*32 +: 32];
    end

    // Search ptr, ptr+1, ... with modulo-NREQ wrap; first valid requester wins.
    always_comb begin
        logic [IDW:0] w_idx;
        w_grant  = '0;
        w_gnt_id = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NREQ)) begin
                w_idx = w_idx - (IDW+1)'(NREQ);
            end
            if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
                w_found                   = 1'b1;
                w_grant[w_idx[IDW-1:0]]   = 1'b1;
                w_gnt_id                  = w_idx[IDW-1:0];
            end
        end
    end

    assign w_slot_free = !r_rsp_valid || rsp_ready;
    assign req_ready   = (w_slot_free && !rst) ? w_grant : '0;
    assign w_accept    = w_found && w_slot_free && !rst;
    assign w_ptr_next  = (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + 1'b1;

    assign w_a   = w_a_arr[w_gnt_id];
    assign w_b   = w_b_arr[w_gnt_id];
    assign w_cin = req_cin[w_gnt_id];

    csa_32bit u_adder (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_ovf = (w_a[31] == w_b[31]) && (w_sum[31] != w_a[31]);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
            r_rsp_ovf   <= 1'b0;
            r_rsp_id    <= '0;
        end else if (w_accept) begin
            r_ptr       <= w_ptr_next;
            r_rsp_valid <= 1'b1;
            r_rsp_sum   <= w_sum;
            r_rsp_cout  <= w_cout;
            r_rsp_ovf   <= w_ovf;
            r_rsp_id    <= w_gnt_id;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;
    assign rsp_ovf   = r_rsp_ovf;
    assign rsp_id    = r_rsp_id;
endmodule

// File: tb/tb_csa_rr_arbiter.sv
// Self-checking bench for csa_rr_arbiter: reference model with a result
// scoreboard, a table of single-request vectors and corner-case sequences.

module tb_csa_rr_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic [1:0]  id;
    } rsp_t;

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ-1:0]    req_cin;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_sum;
    logic               rsp_cout;
    logic               rsp_ovf;
    logic [IDW-1:0]     rsp_id;

    int n_checks = 0;
    int n_errors = 0;

    rsp_t       sb[$];
    logic [1:0] m_ptr   = '0;
    logic       m_valid = 1'b0;

    csa_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [1:0] ptr, input logic [3:0] v);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic step();
        int         g;
        logic [3:0] exp_ready;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] full;
        rsp_t       r;
        @(negedge clk);
        g         = pick(m_ptr, req_valid);
        exp_ready = (!rst && (!m_valid || rsp_ready) && g >= 0) ? 4'(1 << g) : 4'b0000;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        if (m_valid) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(1), 64'(0));
            end else begin
                check("rsp_data", 64'({rsp_sum, rsp_cout, rsp_ovf, rsp_id}), 64'(sb[0]));
                if (rsp_ready && !rst) void'(sb.pop_front());
            end
        end
        @(posedge clk);
        if (rst) begin
            m_ptr   = '0;
            m_valid = 1'b0;
            sb.delete();
        end else if (exp_ready != 4'b0000) begin
            a      = req_a[g*32 +: 32];
            b      = req_b[g*32 +: 32];
            full   = {1'b0, a} + {1'b0, b} + 33'(req_cin[g]);
            r.sum  = full[31:0];
            r.cout = full[32];
            r.ovf  = (a[31] == b[31]) && (full[31] != a[31]);
            r.id   = 2'(g);
            sb.push_back(r);
            m_valid = 1'b1;
            m_ptr   = 2'((g + 1) % NREQ);
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1] = '{1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
        tbl[2] = '{0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        tbl[3] = '{3, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        tbl[4] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[5] = '{0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
        tbl[6] = '{3, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        tbl[7] = '{2, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        req_cin   = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*32 +: 32] = 32'h1000_0000 * (i + 1);
            req_b[i*32 +: 32] = 32'h0000_0100 * (i + 1);
        end
        #1;

        // Reset held two cycles with every requester valid.
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_sum",  64'(rsp_sum),  64'(0));
        check("rst_cout", 64'(rsp_cout), 64'(0));
        check("rst_ovf",  64'(rsp_ovf),  64'(0));
        check("rst_id",   64'(rsp_id),   64'(0));
        check("rst_first_grant", 64'(req_ready), 64'(4'b0001));
        step();
        check("rst_first_id", 64'(rsp_id), 64'(0));
        req_valid = '0;
        step();

        // Single-requester vectors with hand-derived results.
        for (int i = 0; i < 8; i++) begin
            req_valid                  = 4'(1 << tbl[i].id);
            req_a[tbl[i].id*32 +: 32]  = tbl[i].a;
            req_b[tbl[i].id*32 +: 32]  = tbl[i].b;
            req_cin[tbl[i].id]         = tbl[i].cin;
            step();
            req_valid = '0;
            check("tbl_valid", 64'(rsp_valid), 64'(1));
            check("tbl_sum",   64'(rsp_sum),   64'(tbl[i].sum));
            check("tbl_cout",  64'(rsp_cout),  64'(tbl[i].cout));
            check("tbl_ovf",   64'(rsp_ovf),   64'(tbl[i].ovf));
            check("tbl_id",    64'(rsp_id),    64'(tbl[i].id));
            step();
        end

        // Rotation: all requesters valid, consumer always ready.
        rst = 1'b1;
        step();
        step();
        rst       = 1'b0;
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("rot_valid", 64'(rsp_valid), 64'(1));
            check("rot_id",    64'(rsp_id),    64'(k % NREQ));
            req_a[(k % NREQ)*32 +: 32] = $urandom;
            req_b[(k % NREQ)*32 +: 32] = $urandom;
            req_cin[k % NREQ]          = 1'($urandom_range(1));
        end

        // Backpressure: result from requester 3 pending, consumer stalls.
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_ready", 64'(req_ready), 64'(0));
            check("bp_id",    64'(rsp_id),    64'(3));
            check("bp_valid", 64'(rsp_valid), 64'(1));
        end
        rsp_ready = 1'b1;
        step();
        check("bp_refill_valid", 64'(rsp_valid), 64'(1));
        check("bp_refill_id",    64'(rsp_id),    64'(0));

        // Reset coinciding with a request from requester 3.
        req_valid = 4'b1000;
        rst       = 1'b1;
        step();
        check("mid_rst_valid", 64'(rsp_valid), 64'(0));
        rst       = 1'b0;
        req_valid = '1;
        #1;
        check("mid_rst_ptr", 64'(req_ready), 64'(4'b0001));
        step();
        check("mid_rst_id", 64'(rsp_id), 64'(0));
        req_valid = '0;
        step();
        step();
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
